led_switch_scorer: RTL and testbench

- Parametrised round-based scorer for the LED/switch reaction game.
- Credits each lit LED at most once per round, on the switch's off-to-on edge only.
- Optionally penalises switch edges on unlit LEDs; saturates the score and reports per-round hit count.
- Sits between the LED pattern generator and the score display/HEX driver.

---
 rtl/led_switch_scorer.sv | 143 ++++++++++++++
 tb/tb_led_switch_scorer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_switch_scorer.sv
// led_switch_scorer
// Round-based scorer for the LED/switch reaction game. Sits between the LED
// pattern generator and the score display / HEX driver.
//
// A lit LED is credited at most once per round, and only on the off-to-on
// edge of its switch. When PENALTY_EN is set, an off-to-on edge on an unlit
// channel costs one point. The score saturates at 0 and at 2^SCORE_W-1.
// A positive clamp sets the sticky overflow flag.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   round_start  one-cycle pulse; opens a round (only honoured in IDLE)
//   round_end    one-cycle pulse; closes a round (only honoured in ACTIVE)
//   score_clr    one-cycle pulse; zeros score and overflow in any state
//   leds         current LED pattern, synchronous to clk
//   switches     debounced switch levels, synchronous to clk
//   score        accumulated score
//   hits_last    channels credited in the last completed round
//   busy         high while a round is open
//   score_valid  one-cycle pulse in the tally cycle after a round closes
//   overflow     sticky; set when an add clamps at the maximum
module led_switch_scorer #(
  parameter int N_CH       = 18,
  parameter int SCORE_W    = 8,
  parameter int PENALTY_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       round_start,
  input  logic                       round_end,
  input  logic                       score_clr,
  input  logic [N_CH-1:0]            leds,
  input  logic [N_CH-1:0]            switches,
  output logic [SCORE_W-1:0]         score,
  output logic [$clog2(N_CH+1)-1:0]  hits_last,
  output logic                       busy,
  output logic                       score_valid,
  output logic                       overflow
);

  localparam int CW    = $clog2(N_CH+1);
  localparam int SUM_W = SCORE_W + CW + 1;
  localparam logic signed [SUM_W-1:0] SCORE_MAX =
    {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACTIVE, TALLY} state_t;

  state_t                   state, state_nxt;
  logic [N_CH-1:0]          switches_q;
  logic [N_CH-1:0]          credited;
  logic [CW-1:0]            round_cnt;

  logic [N_CH-1:0]          rise, hit_vec, miss_vec;
  logic [CW-1:0]            hit_cnt, miss_cnt;
  logic signed [SUM_W-1:0]  sum;
  logic [SCORE_W-1:0]       score_sat;
  logic                     sat_hi;

  function automatic logic [CW-1:0] popcount(input logic [N_CH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Returns {clamped_high, saturated score}; clamping at zero is silent.
  function automatic logic [SCORE_W:0] clamp_score(input logic signed [SUM_W-1:0] s);
    if (s < 0)              return '0;
    else if (s > SCORE_MAX) return {1'b1, {SCORE_W{1'b1}}};
    else                    return {1'b0, s[SCORE_W-1:0]};
  endfunction

  // Edge detect and per-cycle score delta
  always_comb begin
    rise     = switches & ~switches_q;
    hit_vec  = rise & leds & ~credited;
    miss_vec = (PENALTY_EN != 0) ? (rise & ~leds) : '0;
    hit_cnt  = popcount(hit_vec);
    miss_cnt = popcount(miss_vec);
    sum      = $signed({{(SUM_W-SCORE_W){1'b0}}, score})
             + $signed({{(SUM_W-CW){1'b0}}, hit_cnt})
             - $signed({{(SUM_W-CW){1'b0}}, miss_cnt});
    {sat_hi, score_sat} = clamp_score(sum);
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    score_valid = 1'b0;
    case (state)
      IDLE:    if (round_start) state_nxt = ACTIVE;
      ACTIVE: begin
        busy = 1'b1;
        if (round_end) state_nxt = TALLY;
      end
      TALLY: begin
        score_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round bookkeeping and score register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      switches_q <= '0;
      credited   <= '0;
      round_cnt  <= '0;
      hits_last  <= '0;
      score      <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      switches_q <= switches;
      case (state)
        IDLE: begin
          if (round_start) begin
            credited  <= '0;
            round_cnt <= '0;
          end
        end
        ACTIVE: begin
          credited  <= credited | hit_vec;
          round_cnt <= round_cnt + hit_cnt;
          score     <= score_sat;
          if (sat_hi) overflow <= 1'b1;
        end
        TALLY:   hits_last <= round_cnt;
        default: ;
      endcase
      // Clear takes priority over any delta applied in the same cycle.
      if (score_clr) begin
        score    <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_switch_scorer.sv
module tb_led_switch_scorer;

  localparam int N = 18;
  localparam int CW = $clog2(N+1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic round_start = 1'b0, round_end = 1'b0, score_clr = 1'b0;
  logic [N-1:0] leds = '0, switches = '0;

  logic [7:0]    score_a;
  logic [3:0]    score_b;
  logic [CW-1:0] hits_a, hits_b;
  logic busy_a, busy_b, vld_a, vld_b, ovf_a, ovf_b;

  // Instance A: 8-bit score with penalties; instance B: 4-bit score, no penalties.
  led_switch_scorer #(.N_CH(N), .SCORE_W(8), .PENALTY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .round_start(round_start), .round_end(round_end),
    .score_clr(score_clr), .leds(leds), .switches(switches), .score(score_a),
    .hits_last(hits_a), .busy(busy_a), .score_valid(vld_a), .overflow(ovf_a));

  led_switch_scorer #(.N_CH(N), .SCORE_W(4), .PENALTY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .round_start(round_start), .round_end(round_end),
    .score_clr(score_clr), .leds(leds), .switches(switches), .score(score_b),
    .hits_last(hits_b), .busy(busy_b), .score_valid(vld_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  typedef struct {
    int sc[2];
    int ov[2];
    int hl;
    int busy;
    int vld;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: game rules with plain integers.
  int m_sc[2] = '{0, 0};
  int m_ov[2] = '{0, 0};
  int m_hl = 0;
  int m_mode = 0;          // 0 idle, 1 round open, 2 tally
  int m_cnt = 0;
  bit m_cred[N];
  bit m_prev[N];
  int scw[2] = '{8, 4};
  int pen[2] = '{1, 0};

  task automatic model_step();
    exp_t e;
    int h, mm, v;
    bit r;
    if (!reset) begin
      m_mode = 0; m_cnt = 0; m_hl = 0;
      for (int i = 0; i < N; i++) begin m_cred[i] = 0; m_prev[i] = 0; end
      for (int k = 0; k < 2; k++) begin m_sc[k] = 0; m_ov[k] = 0; end
    end else begin
      h = 0; mm = 0;
      for (int i = 0; i < N; i++) begin
        r = switches[i] && !m_prev[i];
        m_prev[i] = switches[i];
        if (m_mode == 1 && r) begin
          if (leds[i] && !m_cred[i]) begin h++; m_cred[i] = 1; end
          else if (!leds[i]) mm++;
        end
      end
      if (m_mode == 1) begin
        m_cnt += h;
        for (int k = 0; k < 2; k++) begin
          v = m_sc[k] + h - (pen[k] != 0 ? mm : 0);
          if (v > (1 << scw[k]) - 1) begin v = (1 << scw[k]) - 1; m_ov[k] = 1; end
          if (v < 0) v = 0;
          m_sc[k] = v;
        end
        if (round_end) m_mode = 2;
      end else if (m_mode == 0) begin
        if (round_start) begin
          m_mode = 1; m_cnt = 0;
          for (int i = 0; i < N; i++) m_cred[i] = 0;
        end
      end else begin
        m_hl = m_cnt;
        m_mode = 0;
      end
      if (score_clr) for (int k = 0; k < 2; k++) begin m_sc[k] = 0; m_ov[k] = 0; end
    end
    e.sc = m_sc; e.ov = m_ov; e.hl = m_hl;
    e.busy = (m_mode == 1); e.vld = (m_mode == 2);
    q.push_back(e);
  endtask

  task automatic drive(input bit rs, input bit re, input bit clr,
                       input logic [N-1:0] l, input logic [N-1:0] s, input bit rn = 1'b1);
    @(negedge clk);
    round_start = rs; round_end = re; score_clr = clr;
    leds = l; switches = s; reset = rn;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Monitor: every clock edge that followed a stimulus cycle yields one expectation.
  exp_t me;
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("score_a",     int'(score_a), me.sc[0]);
      chk("score_b",     int'(score_b), me.sc[1]);
      chk("overflow_a",  int'(ovf_a),   me.ov[0]);
      chk("overflow_b",  int'(ovf_b),   me.ov[1]);
      chk("hits_last_a", int'(hits_a),  me.hl);
      chk("hits_last_b", int'(hits_b),  me.hl);
      chk("busy_a",      int'(busy_a),  me.busy);
      chk("busy_b",      int'(busy_b),  me.busy);
      chk("valid_a",     int'(vld_a),   me.vld);
      chk("valid_b",     int'(vld_b),   me.vld);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] sw_r, led_r;
    // Reset
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("reset_score", int'(score_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    drive(0, 0, 0, 0, 0);

    // Two lit channels, two rising edges
    drive(1, 0, 0, 18'h5, 0);
    drive(0, 0, 0, 18'h5, 18'h1);
    drive(0, 0, 0, 18'h5, 18'h5);
    drive(0, 1, 0, 18'h5, 18'h5);
    settle();
    chk("d1_score", int'(score_a), 2);
    chk("d1_valid", int'(vld_a), 1);
    drive(0, 0, 0, 18'h5, 0);
    settle();
    chk("d1_hits_last", int'(hits_a), 2);
    chk("d1_busy", int'(busy_a), 0);
    chk("d1_valid_off", int'(vld_a), 0);

    // Toggling credits once per round
    drive(0, 0, 1, 0, 0);
    for (int r = 0; r < 2; r++) begin
      drive(1, 0, 0, 18'h1, 0);
      drive(0, 0, 0, 18'h1, 18'h1);
      drive(0, 0, 0, 18'h1, 18'h0);
      drive(0, 0, 0, 18'h1, 18'h1);
      drive(0, 0, 0, 18'h1, 18'h0);
      drive(0, 0, 0, 18'h1, 18'h1);
      drive(0, 1, 0, 18'h1, 18'h1);
      drive(0, 0, 0, 18'h1, 0);
      settle();
      chk("d2_score", int'(score_a), r + 1);
    end

    // Switch held before round start does not score until re-raised
    drive(0, 0, 0, 18'h8, 18'h8);
    drive(1, 0, 0, 18'h8, 18'h8);
    drive(0, 0, 0, 18'h8, 18'h8);
    settle();
    chk("d3_held", int'(score_a), 2);
    drive(0, 0, 0, 18'h8, 18'h0);
    drive(0, 0, 0, 18'h8, 18'h8);
    settle();
    chk("d3_reraise", int'(score_a), 3);
    drive(0, 1, 0, 18'h8, 18'h8);
    drive(0, 0, 0, 18'h8, 0);

    // Penalty floor at zero and penalty on/off
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 18'h20);
    settle();
    chk("d4_floor", int'(score_a), 0);
    chk("d4_floor_ovf", int'(ovf_a), 0);
    drive(0, 0, 0, 18'hF, 18'hF);
    drive(0, 0, 0, 18'hF, 18'h2F);
    settle();
    chk("d4_penalty_a", int'(score_a), 3);
    chk("d4_nopenalty_b", int'(score_b), 4);
    drive(0, 1, 0, 18'hF, 18'h2F);
    drive(0, 0, 0, 18'hF, 0);

    // Saturation on the 4-bit instance
    for (int r = 0; r < 2; r++) begin
      drive(1, 0, 0, 18'hF, 0);
      drive(0, 0, 0, 18'hF, 18'hF);
      drive(0, 1, 0, 18'hF, 18'hF);
      drive(0, 0, 0, 18'hF, 0);
    end
    drive(1, 0, 0, 18'h3, 0);
    drive(0, 0, 0, 18'h3, 18'h3);
    drive(0, 1, 0, 18'h3, 18'h3);
    drive(0, 0, 0, 18'h3, 0);
    settle();
    chk("d5_pre_b", int'(score_b), 14);
    drive(1, 0, 0, 18'hF, 0);
    drive(0, 0, 0, 18'hF, 18'hF);
    settle();
    chk("d5_sat_b", int'(score_b), 15);
    chk("d5_ovf_b", int'(ovf_b), 1);
    chk("d5_a", int'(score_a), 17);
    chk("d5_ovf_a", int'(ovf_a), 0);
    drive(0, 1, 0, 18'hF, 18'hF);
    drive(0, 0, 0, 18'hF, 0);
    settle();
    chk("d5_hits_b", int'(hits_b), 4);
    drive(0, 0, 1, 0, 0);
    settle();
    chk("d5_clr_b", int'(score_b), 0);
    chk("d5_clr_ovf_b", int'(ovf_b), 0);

    // Reset mid-round
    drive(1, 0, 0, 18'h3F, 0);
    drive(0, 0, 0, 18'h3F, 18'h3F);
    settle();
    chk("d6_pre", int'(score_a), 6);
    drive(0, 0, 0, 18'h3F, 18'h3F, 0);
    settle();
    chk("d6_rst_score", int'(score_a), 0);
    chk("d6_rst_busy", int'(busy_a), 0);
    drive(0, 0, 0, 18'h3F, 0);
    drive(0, 0, 0, 18'h3F, 18'h3F);
    settle();
    chk("d6_no_round", int'(score_a), 0);

    // Randomised play
    sw_r = '0; led_r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) led_r = N'($urandom);
      sw_r = sw_r ^ (N'($urandom) & N'($urandom) & N'($urandom));
      drive($urandom_range(11) == 0, $urandom_range(9) == 0, $urandom_range(59) == 0,
            led_r, sw_r, $urandom_range(299) != 0);
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #5;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
